// File: rtl/stage_memory_access_stbuf_if.sv
// Cache-side port bundle of the MEM-stage store buffer: load read port and store drain handshake.
// master = store buffer side, slave = data cache side.
interface stage_memory_access_stbuf_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] cache_rd_addr;
    logic [31:0]           cache_rd_data;
    logic                  cache_stall;
    logic                  cache_wr_req;
    logic [ADDR_WIDTH-1:0] cache_wr_addr;
    logic [31:0]           cache_wr_data;
    logic [3:0]            cache_wr_be;
    logic                  cache_wr_ack;

    modport master (
        output cache_rd_addr,
        input  cache_rd_data,
        input  cache_stall,
        output cache_wr_req,
        output cache_wr_addr,
        output cache_wr_data,
        output cache_wr_be,
        input  cache_wr_ack
    );

    modport slave (
        input  cache_rd_addr,
        output cache_rd_data,
        output cache_stall,
        input  cache_wr_req,
        input  cache_wr_addr,
        input  cache_wr_data,
        input  cache_wr_be,
        output cache_wr_ack
    );
endinterface

// File: rtl/stage_memory_access_stbuf.sv
// MEM-stage store buffer: FIFO of committed stores drained to the cache, byte-wise load forwarding.
// Optional store coalescing into the youngest entry is enabled by defining STBUF_COALESCE_EN.
module stage_memory_access_stbuf #(
    parameter int STBUF_DEPTH = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           st_valid,
    input  logic [ADDR_WIDTH-1:0]          st_addr,
    input  logic [31:0]                    st_data,
    input  logic [3:0]                     st_be,
    input  logic                           ld_valid,
    input  logic [ADDR_WIDTH-1:0]          ld_addr,
    output logic [31:0]                    ld_rdata,
    output logic                           mem_stall,
    input  logic                           flush,
    output logic                           flush_done,
    output logic [$clog2(STBUF_DEPTH):0]   stbuf_count,
    stage_memory_access_stbuf_if.master    cache
);
    localparam int PW  = $clog2(STBUF_DEPTH);
    localparam int CW  = PW + 1;
    localparam int WAW = ADDR_WIDTH - 2;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_DRAIN      = 2'd1;
    localparam logic [1:0] S_FLUSH_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [STBUF_DEPTH-1:0] valid_q, valid_d;
    logic [WAW-1:0] waddr_q [STBUF_DEPTH];
    logic [WAW-1:0] waddr_d [STBUF_DEPTH];
    logic [31:0]    data_q  [STBUF_DEPTH];
    logic [31:0]    data_d  [STBUF_DEPTH];
    logic [3:0]     be_q    [STBUF_DEPTH];
    logic [3:0]     be_d    [STBUF_DEPTH];

    logic [WAW-1:0] st_waddr, ld_waddr;
    logic [PW-1:0]  tail_idx, scan_idx;
    logic           full, wr_req, pop, st_req, coalesce_hit;
    logic           full_stall, flush_stall, load_stall, accept, push, merge;
    logic [3:0]     fwd_mask;
    logic           unused_addr_lsbs;

    assign st_waddr         = st_addr[ADDR_WIDTH-1:2];
    assign ld_waddr         = ld_addr[ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};
    assign full             = (count_q == CW'(STBUF_DEPTH));
    assign tail_idx         = wr_ptr_q - PW'(1);
    assign wr_req           = (state_q == S_DRAIN) && !cache.cache_stall;
    assign pop              = wr_req && cache.cache_wr_ack;
    assign st_req           = st_valid && (st_be != '0);

`ifdef STBUF_COALESCE_EN
    // The head is frozen while presented to the cache, so it is never a merge target then.
    assign coalesce_hit = (count_q != '0) && (waddr_q[tail_idx] == st_waddr) &&
                          !(wr_req && (tail_idx == rd_ptr_q));
`else
    assign coalesce_hit = 1'b0;
`endif

    // Forwarding: scan oldest to youngest so the youngest matching byte wins.
    always_comb begin
        ld_rdata = cache.cache_rd_data;
        fwd_mask = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < STBUF_DEPTH; k++) begin
            scan_idx = rd_ptr_q + PW'(k);
            if (valid_q[scan_idx] && (waddr_q[scan_idx] == ld_waddr)) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (be_q[scan_idx][b]) begin
                        fwd_mask[b]      = 1'b1;
                        ld_rdata[b*8 +: 8] = data_q[scan_idx][b*8 +: 8];
                    end
                end
            end
        end
    end

    assign full_stall  = st_req && full && !coalesce_hit;
    assign flush_stall = flush && st_valid;
    assign load_stall  = ld_valid && (fwd_mask != 4'hF) && cache.cache_stall;
    assign mem_stall   = full_stall | flush_stall | load_stall;
    // A frozen pipeline re-presents the same store, so nothing is accepted during any stall.
    assign accept      = st_req && !mem_stall;
    assign push        = accept && !coalesce_hit;
    assign merge       = accept && coalesce_hit;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        waddr_d  = waddr_q;
        data_d   = data_q;
        be_d     = be_q;
        count_d  = count_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            waddr_d[wr_ptr_q] = st_waddr;
            data_d[wr_ptr_q]  = st_data;
            be_d[wr_ptr_q]    = st_be;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (merge) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (st_be[b]) data_d[tail_idx][b*8 +: 8] = st_data[b*8 +: 8];
            end
            be_d[tail_idx] = be_q[tail_idx] | st_be;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !cache.cache_stall) state_d = S_DRAIN;
                else if (flush && (count_q == '0))         state_d = S_FLUSH_DONE;
            end
            S_DRAIN: begin
                if (pop && (count_d == '0)) state_d = flush ? S_FLUSH_DONE : S_IDLE;
            end
            S_FLUSH_DONE: state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            waddr_q  <= '{default: '0};
            data_q   <= '{default: '0};
            be_q     <= '{default: '0};
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            waddr_q  <= waddr_d;
            data_q   <= data_d;
            be_q     <= be_d;
        end
    end

    assign flush_done          = (state_q == S_FLUSH_DONE);
    assign stbuf_count         = count_q;
    assign cache.cache_rd_addr = ld_addr;
    assign cache.cache_wr_req  = wr_req;
    assign cache.cache_wr_addr = {waddr_q[rd_ptr_q], 2'b00};
    assign cache.cache_wr_data = data_q[rd_ptr_q];
    assign cache.cache_wr_be   = be_q[rd_ptr_q];
endmodule

// File: tb/tb_stage_memory_access_stbuf.sv
// Self-checking bench for stage_memory_access_stbuf: directed scenarios plus random traffic
// against a queue-based reference model. Honours STBUF_COALESCE_EN like the design.
module tb_stage_memory_access_stbuf;
    localparam int D  = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          st_valid, ld_valid, flush;
    logic [AW-1:0] st_addr, ld_addr;
    logic [31:0]   st_data, ld_rdata;
    logic [3:0]    st_be;
    logic          mem_stall, flush_done;
    logic [2:0]    stbuf_count;

    stage_memory_access_stbuf_if #(.ADDR_WIDTH(AW)) cif ();

    stage_memory_access_stbuf #(.STBUF_DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_be       (st_be),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_rdata    (ld_rdata),
        .mem_stall   (mem_stall),
        .flush       (flush),
        .flush_done  (flush_done),
        .stbuf_count (stbuf_count),
        .cache       (cif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    int   m_st;           // 0 idle, 1 draining, 2 flush-done pulse
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   last_pop_cyc = -100;
    logic        obs_req, obs_stall, obs_fd;
    logic [2:0]  obs_cnt;
    logic [31:0] obs_ld;
    logic [3:0]  obs_be;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        st_valid = 0; st_addr = '0; st_data = '0; st_be = '0;
        ld_valid = 0; ld_addr = '0; flush = 0;
        cif.cache_rd_data = '0; cif.cache_stall = 0; cif.cache_wr_ack = 0;
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model at the edge.
    task automatic step();
        int          n;
        logic        e_req, hit, e_stall, st_req, acc, pop, e_fd;
        logic [3:0]  fwd;
        logic [31:0] e_ld;
        logic [29:0] swa, lwa;
        @(negedge clk);
        cyc++;
        n     = q.size();
        swa   = st_addr[31:2];
        lwa   = ld_addr[31:2];
        e_req = (m_st == 1) && !cif.cache_stall;
        e_fd  = (m_st == 2);
        st_req = st_valid && (st_be != 0);
`ifdef STBUF_COALESCE_EN
        hit = (n > 0) && (q[n-1].wa == swa) && !(e_req && n == 1);
`else
        hit = 1'b0;
`endif
        fwd  = '0;
        e_ld = cif.cache_rd_data;
        for (int b = 0; b < 4; b++) begin
            for (int j = n - 1; j >= 0; j--) begin
                if (q[j].wa == lwa && q[j].be[b]) begin
                    fwd[b] = 1'b1;
                    e_ld[b*8 +: 8] = q[j].d[b*8 +: 8];
                    break;
                end
            end
        end
        e_stall = (st_req && n == D && !hit) || (flush && st_valid) ||
                  (ld_valid && fwd != 4'hF && cif.cache_stall);
        acc = st_req && !e_stall;
        pop = e_req && cif.cache_wr_ack;

        check("count", stbuf_count, n);
        check("wr_req", cif.cache_wr_req, e_req);
        check("flush_done", flush_done, e_fd);
        check("mem_stall", mem_stall, e_stall);
        check("rd_addr", cif.cache_rd_addr, ld_addr);
        if (ld_valid && !e_stall) check("ld_rdata", ld_rdata, e_ld);
        if (e_req && n > 0) begin
            check("wr_addr", cif.cache_wr_addr, {q[0].wa, 2'b00});
            check("wr_data", cif.cache_wr_data, q[0].d);
            check("wr_be", cif.cache_wr_be, q[0].be);
        end
        obs_req = cif.cache_wr_req; obs_stall = mem_stall; obs_fd = flush_done;
        obs_cnt = stbuf_count; obs_ld = ld_rdata; obs_be = cif.cache_wr_be;

        @(posedge clk);
        if (acc && hit) begin
            for (int b = 0; b < 4; b++)
                if (st_be[b]) q[n-1].d[b*8 +: 8] = st_data[b*8 +: 8];
            q[n-1].be = q[n-1].be | st_be;
        end
        if (pop) begin
            void'(q.pop_front());
            last_pop_cyc = cyc;
        end
        if (acc && !hit) q.push_back('{wa: swa, d: st_data, be: st_be});
        case (m_st)
            0: if (n > 0 && !cif.cache_stall) m_st = 1;
               else if (flush && n == 0) m_st = 2;
            1: if (pop && q.size() == 0) m_st = flush ? 2 : 0;
            default: m_st = 0;
        endcase
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1; st_addr = a; st_data = d; st_be = be;
        step();
        st_valid = 0;
    endtask

    task automatic drain_all();
        cif.cache_stall = 0; cif.cache_wr_ack = 1; ld_valid = 0;
        for (int i = 0; i < 30 && q.size() != 0; i++) step();
        check("drain_empty", stbuf_count, 0);
        cif.cache_wr_ack = 0;
        step();
    endtask

    initial begin
        int fd_cyc;
        idle_inputs();
        reset_n = 0;
        q.delete(); m_st = 0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_count", stbuf_count, 0);
        check("rst_req", cif.cache_wr_req, 0);
        check("rst_fd", flush_done, 0);
        check("rst_stall", mem_stall, 0);
        reset_n = 1;

        // word store, ack withheld
        store(32'h100, 32'hDEADBEEF, 4'hF);
        step(); step();
        check("t1_count", obs_cnt, 1);
        check("t1_req", obs_req, 1);
        check("t1_addr", cif.cache_wr_addr, 32'h100);
        check("t1_be", obs_be, 4'hF);

        // partial store forwarded over cache bytes
        store(32'h104, 32'h0000AB00, 4'b0010);
        ld_valid = 1; ld_addr = 32'h104; cif.cache_rd_data = 32'h11223344;
        step();
        check("t2_ld", obs_ld, 32'h1122AB44);
        ld_valid = 0;

        // full buffer stall and retry after one ack
        store(32'h108, 32'h08080808, 4'hF);
        store(32'h10C, 32'h0C0C0C0C, 4'hF);
        st_valid = 1; st_addr = 32'h110; st_data = 32'h10101010; st_be = 4'hF;
        step();
        check("t3_stall", obs_stall, 1);
        check("t3_count", obs_cnt, 4);
        cif.cache_wr_ack = 1; step();
        cif.cache_wr_ack = 0; step();
        st_valid = 0; step();
        check("t3_refill", obs_cnt, 4);
        drain_all();

        // flush completes one cycle after the last ack
        store(32'h180, 32'h1, 4'hF);
        store(32'h184, 32'h2, 4'hF);
        store(32'h188, 32'h3, 4'hF);
        flush = 1; cif.cache_wr_ack = 1;
        fd_cyc = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (obs_fd) begin fd_cyc = cyc; break; end
        end
        check("t4_fd_seen", (fd_cyc >= 0), 1);
        check("t4_fd_gap", fd_cyc - last_pop_cyc, 1);
        flush = 0; cif.cache_wr_ack = 0;
        step();
        check("t4_count", obs_cnt, 0);

        // load-miss stall only when a cache byte is needed
        ld_valid = 1; ld_addr = 32'h300; cif.cache_stall = 1;
        step();
        check("t5_miss_stall", obs_stall, 1);
        ld_valid = 0; cif.cache_stall = 0;
        store(32'h140, 32'hCAFEF00D, 4'hF);
        ld_valid = 1; ld_addr = 32'h140; cif.cache_stall = 1;
        step();
        check("t5_fwd_nostall", obs_stall, 0);
        drain_all();

        // two byte stores to the same word
        cif.cache_stall = 1;
        store(32'h200, 32'h000000AA, 4'b0001);
        store(32'h200, 32'h00CC0000, 4'b0100);
        step();
        cif.cache_stall = 0;
        step(); step();
        check("t6_req", obs_req, 1);
`ifdef STBUF_COALESCE_EN
        check("t6_count", obs_cnt, 1);
        check("t6_be", obs_be, 4'b0101);
`else
        check("t6_count", obs_cnt, 2);
        check("t6_be", obs_be, 4'b0001);
`endif
        drain_all();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            st_valid = ($urandom_range(0, 99) < 50);
            st_addr  = {24'h0, 2'b01, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 7))};
            st_data  = $urandom;
            st_be    = 4'($urandom_range(0, 15));
            ld_valid = ($urandom_range(0, 99) < 50);
            ld_addr  = {24'h0, 2'b01, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 7))};
            cif.cache_rd_data = $urandom;
            cif.cache_stall   = ($urandom_range(0, 99) < 20);
            cif.cache_wr_ack  = ($urandom_range(0, 99) < 60);
            if (!flush && $urandom_range(0, 99) < 3) flush = 1;
            step();
            if (obs_fd) flush = 0;
        end
        idle_inputs();
        drain_all();

        // asynchronous reset while a store is being presented
        store(32'h240, 32'h55AA55AA, 4'hF);
        for (int i = 0; i < 5 && !obs_req; i++) step();
        check("pre_rst_req", cif.cache_wr_req, (m_st == 1));
        #2 reset_n = 0;
        #1;
        check("async_req", cif.cache_wr_req, 0);
        check("async_count", stbuf_count, 0);
        q.delete(); m_st = 0;
        @(posedge clk); #1;
        reset_n = 1;
        step();
        check("post_rst_req", obs_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
